// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM copy engine: op codes, FSM states, default widths.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL_WR,
    ST_CPY_RD,
    ST_CPY_WR,
    ST_SUM_RD,
    ST_SUM_TAIL,
    ST_VFY_RD,
    ST_VFY_TAIL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_addr_gen.sv
// Base/index address generator: wrapped RAM address plus first/last beat flags.
module ram_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [ADDR_W:0]   len_in,
  input  logic              sel_dst,
  input  logic              step,
  input  logic              rewind,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      len_d = len_in;
      idx_d = '0;
    end else if (rewind) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = idx_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  // Truncating the sum gives the modulo-depth wrap for free.
  assign addr  = (sel_dst ? dst_q : src_q) + idx_q[ADDR_W-1:0];
  assign first = (idx_q == '0);
  assign last  = (idx_q == len_q - (ADDR_W+1)'(1));

endmodule

// File: rtl/ram_copy_engine.sv
// FILL / COPY / CHECKSUM master for a single-port synchronous RAM.
// Optional readback verify after FILL: define RAM_COPY_READBACK_VERIFY_EN.
module ram_copy_engine
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [ADDR_W-1:0]        dst_addr,
  input  logic [ADDR_W:0]          len,
  input  logic [DATA_W-1:0]        fill_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_W+ADDR_W-1:0] result,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_cs,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int              SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] b);
    return {{ADDR_W{1'b0}}, b};
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic              gen_load, gen_step, gen_rewind, gen_sel_dst;
  logic              gen_first, gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic              cs_c, we_c;
  logic [DATA_W-1:0] wdata_c;
  logic              cmd_bad;

  assign cmd_bad = (len == '0) || (len > DEPTH) || (op == OP_RSVD);

  ram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (len),
    .sel_dst (gen_sel_dst),
    .step    (gen_step),
    .rewind  (gen_rewind),
    .addr    (gen_addr),
    .first   (gen_first),
    .last    (gen_last)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    err_d       = err_q;
    sum_d       = sum_q;
    gen_load    = 1'b0;
    gen_step    = 1'b0;
    gen_rewind  = 1'b0;
    gen_sel_dst = 1'b0;
    cs_c        = 1'b0;
    we_c        = 1'b0;
    wdata_c     = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gen_load = 1'b1;
          fill_d   = fill_data;
          sum_d    = '0;
          err_d    = cmd_bad;
          if (cmd_bad)             state_d = ST_DONE;
          else if (op == OP_FILL)  state_d = ST_FILL_WR;
          else if (op == OP_COPY)  state_d = ST_CPY_RD;
          else                     state_d = ST_SUM_RD;
        end
      end
      ST_FILL_WR: begin
        cs_c        = 1'b1;
        we_c        = 1'b1;
        gen_sel_dst = 1'b1;
        wdata_c     = fill_q;
        if (gen_last) begin
`ifdef RAM_COPY_READBACK_VERIFY_EN
          gen_rewind = 1'b1;
          state_d    = ST_VFY_RD;
`else
          state_d    = ST_DONE;
`endif
        end else begin
          gen_step = 1'b1;
        end
      end
      ST_CPY_RD: begin
        cs_c    = 1'b1;
        state_d = ST_CPY_WR;
      end
      ST_CPY_WR: begin
        // Write back the byte the RAM registered from the preceding read.
        cs_c        = 1'b1;
        we_c        = 1'b1;
        gen_sel_dst = 1'b1;
        wdata_c     = mem_rdata;
        if (gen_last) begin
          state_d = ST_DONE;
        end else begin
          gen_step = 1'b1;
          state_d  = ST_CPY_RD;
        end
      end
      ST_SUM_RD: begin
        cs_c = 1'b1;
        if (!gen_first) sum_d = sum_q + zext(mem_rdata);
        if (gen_last) state_d  = ST_SUM_TAIL;
        else          gen_step = 1'b1;
      end
      ST_SUM_TAIL: begin
        sum_d   = sum_q + zext(mem_rdata);
        state_d = ST_DONE;
      end
`ifdef RAM_COPY_READBACK_VERIFY_EN
      ST_VFY_RD: begin
        cs_c        = 1'b1;
        gen_sel_dst = 1'b1;
        if (!gen_first && (mem_rdata != fill_q)) err_d = 1'b1;
        if (gen_last) state_d  = ST_VFY_TAIL;
        else          gen_step = 1'b1;
      end
      ST_VFY_TAIL: begin
        if (mem_rdata != fill_q) err_d = 1'b1;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign err       = done && err_q;
  assign result    = sum_q;
  assign mem_cs    = cs_c;
  assign mem_we    = we_c;
  assign mem_addr  = cs_c ? gen_addr : '0;
  assign mem_wdata = wdata_c;

endmodule
